// File: rtl/reg_wb_scheduler.sv
// Register-file write scheduler: per-register pending-write scoreboard, issue hazard stall,
// and ALU/MEM writeback round-robin arbitration onto a registered write port. Option: SCB_BYPASS_EN.
module reg_wb_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs,
  input  logic [AW-1:0]   iss_rt,
  input  logic            iss_use_rs,
  input  logic            iss_use_rt,
  input  logic            iss_wr_en,
  input  logic [AW-1:0]   iss_wdst,
  output logic            iss_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_dst,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_dst,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wadr,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] busy_vec,
  output logic            err_wb_idle
`ifdef SCB_BYPASS_EN
  ,
  output logic            byp_rs_hit,
  output logic            byp_rt_hit
`endif
);

  typedef enum logic {RR_ALU, RR_MEM} rr_t;

  rr_t             r_rr, w_rr_nxt;
  logic [NREG-1:0] r_busy, w_busy_eff, w_set, w_clr, w_busy_nxt;
  logic            r_rf_we, r_err;
  logic [AW-1:0]   r_rf_wadr;
  logic [DW-1:0]   r_rf_wdata;
  logic            w_alu_gnt, w_mem_gnt, w_gnt, w_err_hit;
  logic [AW-1:0]   w_gnt_dst;
  logic [DW-1:0]   w_gnt_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_rr <= RR_ALU;
    else     r_rr <= w_rr_nxt;
  end

  // Pointer moves only when both sides actually competed.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    w_rr_nxt  = r_rr;
    if (alu_valid && mem_valid) begin
      if (r_rr == RR_ALU) begin
        w_alu_gnt = 1'b1;
        w_rr_nxt  = RR_MEM;
      end else begin
        w_mem_gnt = 1'b1;
        w_rr_nxt  = RR_ALU;
      end
    end else begin
      w_alu_gnt = alu_valid;
      w_mem_gnt = mem_valid;
    end
  end

  assign w_gnt      = w_alu_gnt | w_mem_gnt;
  assign w_gnt_dst  = w_mem_gnt ? mem_dst  : alu_dst;
  assign w_gnt_data = w_mem_gnt ? mem_data : alu_data;
  assign w_err_hit  = w_gnt && (w_gnt_dst != '0) && !r_busy[w_gnt_dst];

  always_comb begin
    w_clr = '0;
    if (r_rf_we) w_clr[r_rf_wadr] = 1'b1;
  end

`ifdef SCB_BYPASS_EN
  // A bit clearing at the coming edge no longer blocks; decode forwards rf_wdata.
  assign w_busy_eff = r_busy & ~w_clr;
  assign byp_rs_hit = iss_use_rs & r_rf_we & (r_rf_wadr == iss_rs);
  assign byp_rt_hit = iss_use_rt & r_rf_we & (r_rf_wadr == iss_rt);
`else
  assign w_busy_eff = r_busy;
`endif

  assign iss_ready = !((iss_use_rs && w_busy_eff[iss_rs]) ||
                       (iss_use_rt && w_busy_eff[iss_rt]) ||
                       (iss_wr_en  && w_busy_eff[iss_wdst]));

  // Set after clear so a new issue keeps ownership of a register retiring this edge.
  always_comb begin
    w_set = '0;
    if (iss_valid && iss_ready && iss_wr_en && (iss_wdst != '0)) w_set[iss_wdst] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy     <= '0;
      r_rf_we    <= 1'b0;
      r_rf_wadr  <= '0;
      r_rf_wdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_rf_we <= w_gnt && (w_gnt_dst != '0);
      if (w_gnt && (w_gnt_dst != '0)) begin
        r_rf_wadr  <= w_gnt_dst;
        r_rf_wdata <= w_gnt_data;
      end
      if (w_err_hit) r_err <= 1'b1;
    end
  end

  assign alu_ready   = w_alu_gnt;
  assign mem_ready   = w_mem_gnt;
  assign rf_we       = r_rf_we;
  assign rf_wadr     = r_rf_wadr;
  assign rf_wdata    = r_rf_wdata;
  assign busy_vec    = r_busy;
  assign err_wb_idle = r_err;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler: inputs change at the falling edge, checks 1 time unit later.
module tb_reg_wb_scheduler;
  logic        CLK = 1'b0;
  logic        RST;
  logic        iss_valid, iss_use_rs, iss_use_rt, iss_wr_en, iss_ready;
  logic [4:0]  iss_rs, iss_rt, iss_wdst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_dst, mem_dst;
  logic [31:0] alu_data, mem_data;
  logic        rf_we, err_wb_idle;
  logic [4:0]  rf_wadr;
  logic [31:0] rf_wdata, busy_vec;
`ifdef SCB_BYPASS_EN
  logic        byp_rs_hit, byp_rt_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  reg_wb_scheduler dut (
    .CLK(CLK), .RST(RST),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
    .iss_wr_en(iss_wr_en), .iss_wdst(iss_wdst), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .err_wb_idle(err_wb_idle)
`ifdef SCB_BYPASS_EN
    , .byp_rs_hit(byp_rs_hit), .byp_rt_hit(byp_rt_hit)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_use_rs = 0; iss_use_rt = 0;
    iss_wr_en = 0; iss_wdst = 0;
    alu_valid = 0; alu_dst = 0; alu_data = 0;
    mem_valid = 0; mem_dst = 0; mem_data = 0;
    #8;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_we", {31'b0, rf_we}, 32'h0);
    chk("rst_wadr", {27'b0, rf_wadr}, 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_err", {31'b0, err_wb_idle}, 32'h0);
    #4 RST = 1'b0;

    // issue wdst=5
    step(); iss_valid = 1; iss_wr_en = 1; iss_wdst = 5;
    #1 chk("iss5_ready", {31'b0, iss_ready}, 32'h1);
    // dependent issue on rs=5 stalls
    step(); iss_wr_en = 0; iss_wdst = 0; iss_use_rs = 1; iss_rs = 5;
    #1 chk("busy_5", busy_vec, 32'h20);
    chk("raw_stall", {31'b0, iss_ready}, 32'h0);
    // cycle N: ALU writeback to 5
    step(); alu_valid = 1; alu_dst = 5; alu_data = 32'h1234;
    #1 chk("alu_gnt_N", {31'b0, alu_ready}, 32'h1);
    chk("stall_N", {31'b0, iss_ready}, 32'h0);
    // cycle N+1
    step(); alu_valid = 0;
    #1 chk("we_N1", {31'b0, rf_we}, 32'h1);
    chk("wadr_N1", {27'b0, rf_wadr}, 32'h5);
    chk("wdata_N1", rf_wdata, 32'h1234);
    chk("busy_N1", busy_vec, 32'h20);
`ifdef SCB_BYPASS_EN
    chk("ready_N1_byp", {31'b0, iss_ready}, 32'h1);
    chk("byp_rs_N1", {31'b0, byp_rs_hit}, 32'h1);
`else
    chk("ready_N1", {31'b0, iss_ready}, 32'h0);
`endif
    // cycle N+2
    step();
    #1 chk("busy_N2", busy_vec, 32'h0);
    chk("ready_N2", {31'b0, iss_ready}, 32'h1);
    chk("we_N2", {31'b0, rf_we}, 32'h0);
    iss_use_rs = 0; iss_rs = 0;

    // pend 7, 8, 9
    step(); iss_wr_en = 1; iss_wdst = 7;
    #1 chk("iss7_ready", {31'b0, iss_ready}, 32'h1);
    step(); iss_wdst = 8;
    step(); iss_wdst = 9;
    step(); iss_valid = 0; iss_wr_en = 0; iss_wdst = 0;
    #1 chk("busy_789", busy_vec, 32'h380);
    // WAW stall on 8
    iss_valid = 1; iss_wr_en = 1; iss_wdst = 8;
    #1 chk("waw_stall", {31'b0, iss_ready}, 32'h0);
    iss_valid = 0; iss_wr_en = 0; iss_wdst = 0;

    // contested arbitration: ALU 7, MEM 8, ALU 9
    step(); alu_valid = 1; alu_dst = 7; alu_data = 32'h77;
    mem_valid = 1; mem_dst = 8; mem_data = 32'h88;
    #1 chk("arb1_alu", {31'b0, alu_ready}, 32'h1);
    chk("arb1_mem", {31'b0, mem_ready}, 32'h0);
    step(); alu_dst = 9; alu_data = 32'h99;
    #1 chk("arb2_alu", {31'b0, alu_ready}, 32'h0);
    chk("arb2_mem", {31'b0, mem_ready}, 32'h1);
    chk("arb2_wadr", {27'b0, rf_wadr}, 32'h7);
    chk("arb2_wdata", rf_wdata, 32'h77);
    step(); mem_dst = 12; mem_data = 32'hC0C;
    #1 chk("arb3_alu", {31'b0, alu_ready}, 32'h1);
    chk("arb3_mem", {31'b0, mem_ready}, 32'h0);
    chk("arb3_wadr", {27'b0, rf_wadr}, 32'h8);
    chk("arb3_wdata", rf_wdata, 32'h88);
    chk("arb3_busy", busy_vec, 32'h300);
    // MEM alone to idle register 12
    step(); alu_valid = 0;
    #1 chk("idle_mem_gnt", {31'b0, mem_ready}, 32'h1);
    chk("arb4_wadr", {27'b0, rf_wadr}, 32'h9);
    chk("arb4_we", {31'b0, rf_we}, 32'h1);
    chk("err_before", {31'b0, err_wb_idle}, 32'h0);
    step(); mem_valid = 0;
    #1 chk("err_set", {31'b0, err_wb_idle}, 32'h1);
    chk("idle_we", {31'b0, rf_we}, 32'h1);
    chk("idle_wadr", {27'b0, rf_wadr}, 32'hC);
    chk("idle_wdata", rf_wdata, 32'hC0C);
    chk("busy_clear_all", busy_vec, 32'h0);
    step();
    #1 chk("we_idle_off", {31'b0, rf_we}, 32'h0);
    chk("err_sticky", {31'b0, err_wb_idle}, 32'h1);

    // register 0: never busy, never written, grant still given
    iss_valid = 1; iss_wr_en = 1; iss_wdst = 0;
    alu_valid = 1; alu_dst = 0; alu_data = 32'hDEAD;
    #1 chk("r0_iss_ready", {31'b0, iss_ready}, 32'h1);
    chk("r0_alu_gnt", {31'b0, alu_ready}, 32'h1);
    step(); iss_valid = 0; iss_wr_en = 0; alu_valid = 0; alu_data = 0;
    #1 chk("r0_busy", busy_vec, 32'h0);
    chk("r0_we", {31'b0, rf_we}, 32'h0);
    chk("r0_err_sticky", {31'b0, err_wb_idle}, 32'h1);

    // async reset with a write in flight
    iss_valid = 1; iss_wr_en = 1; iss_wdst = 9;
    step(); iss_valid = 0; iss_wr_en = 0; iss_wdst = 0;
    alu_valid = 1; alu_dst = 9; alu_data = 32'h55;
    #1 chk("rst_pre_gnt", {31'b0, alu_ready}, 32'h1);
    step(); alu_valid = 0;
    #1 chk("rst_pre_we", {31'b0, rf_we}, 32'h1);
    chk("rst_pre_busy", busy_vec, 32'h200);
    #1 RST = 1'b1;
    #1 chk("arst_we", {31'b0, rf_we}, 32'h0);
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_err", {31'b0, err_wb_idle}, 32'h0);
    chk("arst_wadr", {27'b0, rf_wadr}, 32'h0);
    step(); RST = 1'b0;
    // pointer back to ALU-first after reset
    step(); alu_valid = 1; mem_valid = 1; alu_dst = 0; mem_dst = 0;
    #1 chk("arst_rr_alu", {31'b0, alu_ready}, 32'h1);
    chk("arst_rr_mem", {31'b0, mem_ready}, 32'h0);
    step(); alu_valid = 0; mem_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
